// File: rtl/tx_stream_arbiter_if.sv
// Handshake bundle between the TX stream arbiter, the general-data source, the ADC FIFO and the UART.
// master = arbiter side, slave = environment side (sources, ADC FIFO, UART).
interface tx_stream_arbiter_if;
  logic [7:0] gen_data;
  logic       gen_write;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       adc_strobe;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       gen_overflow;
  logic [2:0] state;

  modport master (
    input  gen_data, gen_write, adc_data, adc_valid, tx_busy,
    output adc_strobe, tx_data, tx_start, gen_overflow, state
  );

  modport slave (
    output gen_data, gen_write, adc_data, adc_valid, tx_busy,
    input  adc_strobe, tx_data, tx_start, gen_overflow, state
  );
endinterface

// File: rtl/tx_stream_arbiter.sv
// Purpose: shares one UART between queued command-response bytes and headered ADC bursts.
// Latency: TxStart 1 cycle after TxBusy falls in a wait state; backpressure: stalls on TxBusy, drops general bytes when full.

// Purpose: small synchronous FIFO, combinational head (first-word-fall-through).
// Latency: write visible at head 1 cycle later; backpressure: full accepts a write only alongside a read.
module gen_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             rd_vld,
  output logic             full
);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd  = rd_rdy && (count != '0);
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign do_wr  = wr_vld && ((count != DEPTH_C) || do_rd);
  assign rd_dat = mem[rd_ptr];
  assign rd_vld = (count != '0);
  assign full   = (count == DEPTH_C);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_wr && !do_rd) begin
        count <= count + 1'b1;
      end else if (!do_wr && do_rd) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module tx_stream_arbiter #(
  parameter int unsigned BURST_LEN   = 256,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int unsigned GEN_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  tx_stream_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN_SEND = 3'd1,
    GEN_WAIT = 3'd2,
    HDR_SEND = 3'd3,
    ADC_SEND = 3'd4,
    ADC_WAIT = 3'd5
  } state_t;

  localparam logic [15:0] BURST_MAX = 16'(BURST_LEN);

  state_t      state_q;
  state_t      state_d;
  logic        seen_busy_q;
  logic        seen_busy_d;
  logic [15:0] burst_cnt_q;
  logic [15:0] burst_cnt_d;
  logic [7:0]  tx_data_q;
  logic [7:0]  tx_data_d;
  logic        tx_start_q;
  logic        tx_start_d;
  logic        adc_strobe_q;
  logic        adc_strobe_d;
  logic        gen_overflow_q;
  logic        wait_done;

  logic        gen_vld;
  logic        gen_full;
  logic        gen_pop;
  logic [7:0]  gen_head;

  assign gen_pop = (state_q == GEN_SEND);

  gen_fifo #(
    .WIDTH (8),
    .DEPTH (GEN_DEPTH)
  ) u_gen_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (bus.gen_write),
    .wr_dat (bus.gen_data),
    .rd_rdy (gen_pop),
    .rd_dat (gen_head),
    .rd_vld (gen_vld),
    .full   (gen_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seen_busy_q    <= 1'b0;
      burst_cnt_q    <= '0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      adc_strobe_q   <= 1'b0;
      gen_overflow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seen_busy_q  <= seen_busy_d;
      burst_cnt_q  <= burst_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      adc_strobe_q <= adc_strobe_d;
      if (bus.gen_write && gen_full && !gen_pop) begin
        gen_overflow_q <= 1'b1;
      end
    end
  end

  // The byte is finished only once the UART has been seen busy and then idle again.
  assign wait_done = seen_busy_q && !bus.tx_busy;

  // Send-state outputs are decided one cycle early so TxStart/AdcStrobe come straight from flops.
  always_comb begin
    state_d      = state_q;
    seen_busy_d  = seen_busy_q;
    burst_cnt_d  = burst_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    adc_strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        seen_busy_d = 1'b0;
        if (!bus.tx_busy) begin
          if (gen_vld) begin
            state_d    = GEN_SEND;
            tx_start_d = 1'b1;
            tx_data_d  = gen_head;
          end else if (bus.adc_valid) begin
            state_d    = HDR_SEND;
            tx_start_d = 1'b1;
            tx_data_d  = HEADER_BYTE;
          end
        end
      end

      GEN_SEND: begin
        state_d     = GEN_WAIT;
        seen_busy_d = 1'b0;
      end

      GEN_WAIT: begin
        if (bus.tx_busy) begin
          seen_busy_d = 1'b1;
        end
        if (wait_done) begin
          state_d = IDLE;
        end
      end

      HDR_SEND: begin
        state_d     = ADC_WAIT;
        seen_busy_d = 1'b0;
        burst_cnt_d = '0;
      end

      ADC_SEND: begin
        state_d     = ADC_WAIT;
        seen_busy_d = 1'b0;
        if (burst_cnt_q != BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
        end
      end

      ADC_WAIT: begin
        if (bus.tx_busy) begin
          seen_busy_d = 1'b1;
        end
        if (wait_done) begin
          if ((burst_cnt_q < BURST_MAX) && bus.adc_valid) begin
            state_d      = ADC_SEND;
            tx_start_d   = 1'b1;
            adc_strobe_d = 1'b1;
            tx_data_d    = bus.adc_data;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.adc_strobe   = adc_strobe_q;
  assign bus.gen_overflow = gen_overflow_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed bench for tx_stream_arbiter with a UART busy model and a first-word-fall-through ADC FIFO model.
module tb_tx_stream_arbiter;
  localparam int BUSY_CYC = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_stream_arbiter_if bus ();

  tx_stream_arbiter #(
    .BURST_LEN   (4),
    .HEADER_BYTE (8'hA5),
    .GEN_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int         tx_total     = 0;
  int         strobe_total = 0;
  int         dbl_start    = 0;
  int         ubusy_cnt    = 0;
  logic [7:0] tx_log [0:127];

  logic       force_busy = 1'b0;
  logic       adc_en     = 1'b0;
  int         adc_start  = 0;
  int         adc_avail  = 0;
  logic [7:0] adc_mem [0:15];
  int         adc_idx;

  logic [7:0] exp34 [13] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA5, 8'h04, 8'h05, 8'h06, 8'h07, 8'hA5, 8'h08, 8'h09};
  logic [7:0] exp36 [11] = '{8'hA5, 8'h20, 8'h21, 8'h22, 8'h23, 8'h55, 8'hA5, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0] exp38 [8]  = '{8'hA5, 8'h30, 8'h31, 8'h32, 8'h33, 8'hA5, 8'h34, 8'h35};

  always_comb adc_idx = strobe_total - adc_start;
  assign bus.adc_valid = adc_en && (adc_idx < adc_avail);
  assign bus.adc_data  = adc_mem[adc_idx[3:0]];
  assign bus.tx_busy   = (ubusy_cnt != 0) || force_busy;

  // UART model: busy from the cycle after TxStart for BUSY_CYC cycles; logs bytes and flags starts while busy.
  always @(posedge clk) begin
    if (bus.tx_start) begin
      if (bus.tx_busy) dbl_start <= dbl_start + 1;
      tx_log[tx_total[6:0]] <= bus.tx_data;
      tx_total  <= tx_total + 1;
      ubusy_cnt <= BUSY_CYC;
    end else if (ubusy_cnt != 0) begin
      ubusy_cnt <= ubusy_cnt - 1;
    end
    if (bus.adc_strobe) strobe_total <= strobe_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int n = 0;
    while (tx_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_total >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(bus.state == 3'd0 && !bus.tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.state == 3'd0 && !bus.tx_busy), 32'd1);
  endtask

  initial begin
    int base;
    int sbase;
    int n;

    rst = 1'b1;
    bus.gen_write = 1'b0;
    bus.gen_data  = 8'h00;
    for (int i = 0; i < 16; i++) adc_mem[i] = 8'(i);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_adc_strobe", 32'(bus.adc_strobe), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_overflow", 32'(bus.gen_overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single general byte
    bus.gen_data  = 8'h41;
    bus.gen_write = 1'b1;
    @(negedge clk);
    bus.gen_write = 1'b0;
    @(negedge clk);
    check("gen_send_state", 32'(bus.state), 32'd1);
    check("gen_send_start", 32'(bus.tx_start), 32'd1);
    check("gen_send_data", 32'(bus.tx_data), 32'h41);
    @(negedge clk);
    check("gen_wait_state", 32'(bus.state), 32'd2);
    check("gen_wait_start", 32'(bus.tx_start), 32'd0);
    wait_tx(1, 50, "gen_tx_timeout");
    wait_idle(60, "gen_idle_timeout");
    repeat (5) @(negedge clk);
    check("gen_tx_count", 32'(tx_total), 32'd1);
    check("gen_tx_byte", 32'(tx_log[0]), 32'h41);
    check("gen_end_state", 32'(bus.state), 32'd0);
    check("gen_overflow", 32'(bus.gen_overflow), 32'd0);
    check("gen_data_held", 32'(bus.tx_data), 32'h41);

    // ADC bursts of 4 from bytes 0x00..0x09
    base  = tx_total;
    sbase = strobe_total;
    adc_start = strobe_total;
    adc_avail = 10;
    adc_en    = 1'b1;
    wait_tx(base + 13, 600, "adc_tx_timeout");
    wait_idle(60, "adc_idle_timeout");
    repeat (5) @(negedge clk);
    check("adc_tx_count", 32'(tx_total - base), 32'd13);
    for (int i = 0; i < 13; i++) check($sformatf("adc_seq[%0d]", i), 32'(tx_log[base + i]), 32'(exp34[i]));
    check("adc_strobes", 32'(strobe_total - sbase), 32'd10);
    check("adc_end_state", 32'(bus.state), 32'd0);
    adc_en = 1'b0;

    // General byte arriving mid-burst goes out between bursts
    for (int i = 0; i < 8; i++) adc_mem[i] = 8'(8'h20 + i);
    base  = tx_total;
    sbase = strobe_total;
    adc_start = strobe_total;
    adc_avail = 8;
    adc_en    = 1'b1;
    wait_tx(base + 2, 100, "mix_first_timeout");
    bus.gen_data  = 8'h55;
    bus.gen_write = 1'b1;
    @(negedge clk);
    bus.gen_write = 1'b0;
    wait_tx(base + 11, 600, "mix_tx_timeout");
    wait_idle(60, "mix_idle_timeout");
    repeat (5) @(negedge clk);
    check("mix_tx_count", 32'(tx_total - base), 32'd11);
    for (int i = 0; i < 11; i++) check($sformatf("mix_seq[%0d]", i), 32'(tx_log[base + i]), 32'(exp36[i]));
    check("mix_strobes", 32'(strobe_total - sbase), 32'd8);
    adc_en = 1'b0;

    // Five writes into a depth-4 FIFO while the UART is busy
    force_busy = 1'b1;
    base = tx_total;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before_drop", 32'(bus.gen_overflow), 32'd0);
      bus.gen_data  = 8'(8'h10 + i);
      bus.gen_write = 1'b1;
      @(negedge clk);
    end
    bus.gen_write = 1'b0;
    check("ovf_after_drop", 32'(bus.gen_overflow), 32'd1);
    @(negedge clk);
    force_busy = 1'b0;
    wait_tx(base + 4, 300, "ovf_tx_timeout");
    wait_idle(60, "ovf_idle_timeout");
    repeat (5) @(negedge clk);
    check("ovf_tx_count", 32'(tx_total - base), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_seq[%0d]", i), 32'(tx_log[base + i]), 32'(8'h10 + i));
    check("ovf_sticky", 32'(bus.gen_overflow), 32'd1);

    rst = 1'b1;
    #1;
    check("ovf_cleared_by_rst", 32'(bus.gen_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Push and pop in the same cycle with the FIFO full
    force_busy = 1'b1;
    base = tx_total;
    for (int i = 0; i < 4; i++) begin
      bus.gen_data  = 8'(8'h61 + i);
      bus.gen_write = 1'b1;
      @(negedge clk);
    end
    bus.gen_write = 1'b0;
    check("pp_fill_no_ovf", 32'(bus.gen_overflow), 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    check("pp_gen_send", 32'(bus.state), 32'd1);
    bus.gen_data  = 8'h65;
    bus.gen_write = 1'b1;
    @(negedge clk);
    bus.gen_write = 1'b0;
    check("pp_no_ovf", 32'(bus.gen_overflow), 32'd0);
    wait_tx(base + 5, 300, "pp_tx_timeout");
    wait_idle(60, "pp_idle_timeout");
    repeat (5) @(negedge clk);
    check("pp_tx_count", 32'(tx_total - base), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("pp_seq[%0d]", i), 32'(tx_log[base + i]), 32'(8'h61 + i));
    check("pp_ovf_end", 32'(bus.gen_overflow), 32'd0);

    // Reset in ADC_WAIT with the UART busy
    for (int i = 0; i < 6; i++) adc_mem[i] = 8'(8'h30 + i);
    base  = tx_total;
    sbase = strobe_total;
    adc_start = strobe_total;
    adc_avail = 6;
    adc_en    = 1'b1;
    n = 0;
    while (!(bus.state == 3'd5 && bus.tx_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstw_reach_wait", 32'(bus.state == 3'd5 && bus.tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_state", 32'(bus.state), 32'd0);
    check("rstw_tx_start", 32'(bus.tx_start), 32'd0);
    check("rstw_adc_strobe", 32'(bus.adc_strobe), 32'd0);
    check("rstw_tx_data", 32'(bus.tx_data), 32'h00);
    check("rstw_overflow", 32'(bus.gen_overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rstw_pre_count", 32'(tx_total - base), 32'd1);
    base = tx_total;
    @(negedge clk);
    check("rstw_idle_while_busy", 32'(bus.state), 32'd0);
    check("rstw_no_start_busy", 32'(bus.tx_start), 32'd0);
    wait_tx(base + 8, 600, "rstw_tx_timeout");
    wait_idle(60, "rstw_idle_timeout");
    repeat (5) @(negedge clk);
    check("rstw_tx_count", 32'(tx_total - base), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("rstw_seq[%0d]", i), 32'(tx_log[base + i]), 32'(exp38[i]));
    check("rstw_strobes", 32'(strobe_total - sbase), 32'd6);
    adc_en = 1'b0;

    check("no_start_while_busy", 32'(dbl_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 256: max ADC bytes per burst, range 1..65535.
REQ-002 Parameter HEADER_BYTE, default 8'hA5: byte sent before every ADC burst.
REQ-003 Parameter GEN_DEPTH, default 4: general-data FIFO depth, power of 2.
REQ-004 Clock  in  1  system clock, all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 GenData  in  8  command-response byte.
REQ-007 GenWrite  in  1  one-cycle strobe; pushes GenData.
REQ-008 AdcData  in  8  head byte of the ADC storage FIFO (first-word-fall-through).
REQ-009 AdcValid  in  1  ADC FIFO not empty; AdcData valid while high.
REQ-010 AdcStrobe  out  1  one-cycle pop of the ADC FIFO.
REQ-011 TxBusy  in  1  UART busy; rises the cycle after TxStart, falls after the stop bit.
REQ-012 TxData  out  8  byte to the UART, held stable from TxStart until TxBusy falls.
REQ-013 TxStart  out  1  one-cycle UART start pulse.
REQ-014 GenOverflow  out  1  sticky flag: a general byte was dropped.
REQ-015 State  out  3  current FSM state encoding, for status readback.

Function
REQ-016 General FIFO: GEN_DEPTH entries, push on GenWrite when not full, pop when GEN_SEND issues TxStart.
- Push and pop in the same cycle both occur; count is unchanged.
REQ-017 GenWrite while the FIFO is full: byte dropped, FIFO contents unchanged, GenOverflow set to 1 until Reset.
REQ-018 FSM states and encodings: IDLE=0, GEN_SEND=1, GEN_WAIT=2, HDR_SEND=3, ADC_SEND=4, ADC_WAIT=5.
REQ-019 IDLE transitions, evaluated only when TxBusy=0:
- General FIFO not empty -> GEN_SEND (general data has priority).
- Otherwise, AdcValid=1 -> HDR_SEND.
- Otherwise, stay in IDLE.
REQ-020 GEN_SEND: TxStart=1 and TxData=FIFO head for exactly one cycle, pop FIFO, -> GEN_WAIT.
REQ-021 GEN_WAIT: wait for TxBusy to be seen high and then low, then -> IDLE.
REQ-022 HDR_SEND: TxStart=1 with TxData=HEADER_BYTE, clear burst counter to 0, -> ADC_WAIT.
REQ-023 ADC_SEND, entered only with AdcValid=1:
- TxStart=1, TxData=AdcData, AdcStrobe=1 in the same cycle.
- Burst counter +1, -> ADC_WAIT.
REQ-024 ADC_WAIT: after TxBusy has been seen high then low:
- Burst counter < BURST_LEN and AdcValid=1 -> ADC_SEND.
- Otherwise -> IDLE.
REQ-025 On return to IDLE after a burst, a pending general byte wins over a new ADC burst, so command responses wait at most one burst.
REQ-026 AdcValid falling mid-burst ends the burst at the next byte boundary. No padding bytes are sent. A later AdcValid starts a new burst with a new header.
REQ-027 Each wait state latches a seen-busy bit so that TxStart is never issued twice for one byte. Latency from TxBusy falling to the next TxStart is 1 cycle (wait -> send).
REQ-028 TxStart and AdcStrobe are registered outputs. AdcStrobe is asserted only in ADC_SEND. At most one TxStart occurs per byte.
REQ-029 Burst counter is 16 bits and saturates at BURST_LEN; it does not wrap.
REQ-030 TxData holds its last value outside send states.

Reset
REQ-031 Reset asserted returns, immediately:
- State=IDLE, TxStart=0, AdcStrobe=0, TxData=8'h00, GenOverflow=0.
- General FIFO empty, burst counter 0, seen-busy bits 0.
REQ-032 Reset mid-byte abandons the byte. After release, the FSM waits in IDLE until TxBusy=0 before issuing any TxStart.

Verification
REQ-033 GenWrite 0x41, ADC idle, UART model busy 10 cycles -> TxStart once with TxData=0x41; State returns to 0; GenOverflow=0.
REQ-034 AdcValid held, FIFO bytes 0x00..0x09, BURST_LEN=4 -> TX sequence A5,00,01,02,03,A5,04,05,06,07,A5,08,09; 10 AdcStrobe pulses total.
REQ-035 Five GenWrite strobes (0x10..0x14) in consecutive cycles while UART busy, GEN_DEPTH=4 -> 0x10..0x13 sent, 0x14 dropped, GenOverflow=1 until Reset.
REQ-036 GenWrite 0x55 during an ADC burst (BURST_LEN=4, 8 ADC bytes available) -> 0x55 sent after byte 4, before the second A5 header.
REQ-037 Push and pop of the general FIFO in the same cycle with count=GEN_DEPTH -> no drop, GenOverflow stays 0.
REQ-038 Reset asserted in ADC_WAIT with TxBusy=1 -> outputs at reset values immediately; no TxStart until TxBusy=0 after release.
